pipe_stage_buf: RTL

- Parametrised pipeline-stage register for the ARM core, replacing fixed per-stage register blocks.
- Carries a control bundle, which is forced to zero for every bubble, and a data payload.
- Upstream and downstream sides use valid/ready handshakes, with an optional 2-entry skid buffer so a downstream stall does not combinationally stall upstream.
- Supports synchronous flush (branch taken) and freeze (hazard stall). Instances sit between IF/ID, ID/EXE, EXE/MEM and MEM/WB.

---
 rtl/pipe_stage_buf.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshakes, an optional 2-entry skid buffer,
// synchronous flush, and freeze. The control bundle is zeroed on every bubble.
module pipe_stage_buf #(
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned SKID   = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_freeze,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [DATA_W-1:0] o_out_data,
   output logic [1:0]        o_occupancy
);

   localparam bit SKID_EN = (SKID != 0);

   logic              r_m_vld, r_k_vld;
   logic [CTRL_W-1:0] r_m_ctrl, r_k_ctrl;
   logic [DATA_W-1:0] r_m_data, r_k_data;

   logic              w_m_vld_nx, w_k_vld_nx;
   logic [CTRL_W-1:0] w_m_ctrl_nx, w_k_ctrl_nx;
   logic [DATA_W-1:0] w_m_data_nx, w_k_data_nx;

   logic w_rdy_base, w_in_ready, w_out_valid, w_acc, w_emit;

   // With the skid entry, in_ready depends only on K state, so out_ready never reaches upstream.
   assign w_rdy_base  = SKID_EN ? !r_k_vld : (!r_m_vld || i_out_ready);
   assign w_in_ready  = w_rdy_base && !i_freeze && !i_flush;
   assign w_out_valid = r_m_vld && !i_freeze;
   assign w_acc       = i_in_valid && w_in_ready;
   assign w_emit      = w_out_valid && i_out_ready;

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_ctrl  = r_m_ctrl & {CTRL_W{w_out_valid}};
   assign o_out_data  = r_m_data;
   // K is only ever valid when M is valid.
   assign o_occupancy = {r_k_vld, r_m_vld && !r_k_vld};

   always_comb begin
      w_m_vld_nx  = r_m_vld;
      w_m_ctrl_nx = r_m_ctrl;
      w_m_data_nx = r_m_data;
      w_k_vld_nx  = r_k_vld;
      w_k_ctrl_nx = r_k_ctrl;
      w_k_data_nx = r_k_data;
      if (!r_m_vld) begin
         if (w_acc) begin
            w_m_vld_nx  = 1'b1;
            w_m_ctrl_nx = i_in_ctrl;
            w_m_data_nx = i_in_data;
         end
      end else if (!r_k_vld) begin
         if (w_acc && w_emit) begin
            w_m_ctrl_nx = i_in_ctrl;
            w_m_data_nx = i_in_data;
         end else if (w_emit) begin
            w_m_vld_nx  = 1'b0;
            w_m_ctrl_nx = '0;
         end else if (w_acc && SKID_EN) begin
            w_k_vld_nx  = 1'b1;
            w_k_ctrl_nx = i_in_ctrl;
            w_k_data_nx = i_in_data;
         end
      end else if (w_emit) begin
         w_m_ctrl_nx = r_k_ctrl;
         w_m_data_nx = r_k_data;
         w_k_vld_nx  = 1'b0;
         w_k_ctrl_nx = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_m_vld  <= 1'b0;
         r_m_ctrl <= '0;
         r_m_data <= '0;
         r_k_vld  <= 1'b0;
         r_k_ctrl <= '0;
         r_k_data <= '0;
      end else if (i_flush) begin
         r_m_vld  <= 1'b0;
         r_m_ctrl <= '0;
         r_m_data <= '0;
         r_k_vld  <= 1'b0;
         r_k_ctrl <= '0;
         r_k_data <= '0;
      end else begin
         r_m_vld  <= w_m_vld_nx;
         r_m_ctrl <= w_m_ctrl_nx;
         r_m_data <= w_m_data_nx;
         r_k_vld  <= w_k_vld_nx;
         r_k_ctrl <= w_k_ctrl_nx;
         r_k_data <= w_k_data_nx;
      end
   end

   a_occ_bound: assert property (@(posedge i_clk) disable iff (i_rst)
      (!r_k_vld || r_m_vld) && (SKID_EN || !r_k_vld));

endmodule
